// File: rtl/nn_root_manager_if.sv
// Stream bundle between the root manager and its solver neighbours:
// initial-guess load, root beats to the forward engine, error and updated-root beats back.
interface nn_root_manager_if #(
  parameter int W     = 34,
  parameter int IDX_W = 1
);
  logic             init_valid;
  logic             init_ready;
  logic [W-1:0]     init_data;
  logic             fwd_valid;
  logic             fwd_ready;
  logic [W-1:0]     fwd_data;
  logic [IDX_W-1:0] fwd_idx;
  logic             err_valid;
  logic [W-1:0]     err_data;
  logic             upd_valid;
  logic [W-1:0]     upd_data;

  modport slave (
    input  init_valid, init_data, fwd_ready, err_valid, err_data, upd_valid, upd_data,
    output init_ready, fwd_valid, fwd_data, fwd_idx
  );

  modport master (
    output init_valid, init_data, fwd_ready, err_valid, err_data, upd_valid, upd_data,
    input  init_ready, fwd_valid, fwd_data, fwd_idx
  );
endinterface

// File: rtl/nn_root_manager.sv
// Root bank and iteration sequencer for the NN non-linear solver (FloPoCo roots).
// Optional NN_ROOT_BEST_REPLAY_EN: re-stream the best roots on fwd_* before DONE.
module nn_root_manager #(
  parameter int BIT_WIDTH    = 32,
  parameter int EXTRA_BITS   = 2,
  parameter int NUM_UNKNOWNS = 2,
  parameter int MAX_ITER     = 1024,
  parameter int ITER_W       = 16,
  parameter int IDX_W        = 1,
  localparam int W           = BIT_WIDTH + EXTRA_BITS
) (
  input  logic                      CLK,
  input  logic                      RESET,
  input  logic                      start,
  input  logic [W-1:0]              tol,
  nn_root_manager_if.slave          bus,
  output logic [W-1:0]              best_error,
  output logic [NUM_UNKNOWNS*W-1:0] best_roots,
  output logic [ITER_W-1:0]         iter_count,
  output logic                      busy,
  output logic                      done
);

  localparam logic [W-1:0]     POS_INF = {2'b10, {(W-2){1'b0}}};
  localparam logic [IDX_W-1:0] LAST    = IDX_W'(NUM_UNKNOWNS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_STREAM, S_WAIT_ERR, S_WAIT_UPD, S_FINISH, S_DONE
`ifdef NN_ROOT_BEST_REPLAY_EN
    , S_REPLAY
`endif
  } state_t;

  state_t                           state_q, state_d;
  logic [IDX_W-1:0]                 idx_q, idx_d;
  logic [NUM_UNKNOWNS-1:0][W-1:0]   roots_q, roots_d;
  logic [NUM_UNKNOWNS-1:0][W-1:0]   broots_q, broots_d;
  logic [W-1:0]                     best_q, best_d;
  logic [W-1:0]                     tol_q, tol_d;
  logic [ITER_W-1:0]                iter_q, iter_d;

  logic              err_nan;
  logic [ITER_W-1:0] iter_inc;
  logic [IDX_W-1:0]  idx_inc;
  logic              last_idx;

  assign err_nan  = (bus.err_data[W-1 -: 2] == 2'b11);
  assign iter_inc = iter_q + ITER_W'(1);
  assign idx_inc  = idx_q + IDX_W'(1);
  assign last_idx = (idx_q == LAST);

  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    roots_d        = roots_q;
    broots_d       = broots_q;
    best_d         = best_q;
    tol_d          = tol_q;
    iter_d         = iter_q;
    bus.init_ready = 1'b0;
    bus.fwd_valid  = 1'b0;
    bus.fwd_data   = roots_q[idx_q];
    bus.fwd_idx    = idx_q;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        // best_roots is deliberately kept; only best_error restarts at +inf
        if (start) begin
          iter_d  = '0;
          best_d  = POS_INF;
          tol_d   = tol;
          idx_d   = '0;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        bus.init_ready = 1'b1;
        if (bus.init_valid) begin
          roots_d[idx_q] = bus.init_data;
          idx_d          = last_idx ? '0 : idx_inc;
          if (last_idx) state_d = S_STREAM;
        end
      end
      S_STREAM: begin
        bus.fwd_valid = 1'b1;
        if (bus.fwd_ready) begin
          idx_d = last_idx ? '0 : idx_inc;
          if (last_idx) state_d = S_WAIT_ERR;
        end
      end
      S_WAIT_ERR: begin
        if (bus.err_valid) begin
          // strict compare: ties keep the older roots; NaN never wins or meets tol
          if (!err_nan && (bus.err_data < best_q)) begin
            best_d   = bus.err_data;
            broots_d = roots_q;
          end
          iter_d = iter_inc;
          idx_d  = '0;
          if ((!err_nan && (bus.err_data <= tol_q)) || (iter_inc == ITER_W'(MAX_ITER)))
            state_d = S_FINISH;
          else
            state_d = S_WAIT_UPD;
        end
      end
      S_WAIT_UPD: begin
        if (bus.upd_valid) begin
          roots_d[idx_q] = bus.upd_data;
          idx_d          = last_idx ? '0 : idx_inc;
          if (last_idx) state_d = S_STREAM;
        end
      end
      S_FINISH: begin
        idx_d = '0;
`ifdef NN_ROOT_BEST_REPLAY_EN
        state_d = S_REPLAY;
`else
        state_d = S_DONE;
`endif
      end
`ifdef NN_ROOT_BEST_REPLAY_EN
      S_REPLAY: begin
        bus.fwd_valid = 1'b1;
        bus.fwd_data  = broots_q[idx_q];
        if (bus.fwd_ready) begin
          idx_d = last_idx ? '0 : idx_inc;
          if (last_idx) state_d = S_DONE;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      roots_q  <= '0;
      broots_q <= '0;
      best_q   <= POS_INF;
      tol_q    <= '0;
      iter_q   <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      roots_q  <= roots_d;
      broots_q <= broots_d;
      best_q   <= best_d;
      tol_q    <= tol_d;
      iter_q   <= iter_d;
    end
  end

  assign best_error = best_q;
  assign best_roots = broots_q;
  assign iter_count = iter_q;
  assign busy       = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done       = (state_q == S_DONE);

endmodule

// File: tb/tb_nn_root_manager.sv
// Bench for nn_root_manager (N=2, MAX_ITER=4): directed corner sequences, a run table,
// and random runs scored against a list-based model of the iteration rules.
module tb_nn_root_manager;
  localparam int W    = 34;
  localparam int MAXI = 4;

  localparam logic [W-1:0] ZERO = {2'b00, 32'h0};
  localparam logic [W-1:0] ONE  = {2'b01, 32'h3F80_0000};
  localparam logic [W-1:0] TWO  = {2'b01, 32'h4000_0000};
  localparam logic [W-1:0] FOUR = {2'b01, 32'h4080_0000};
  localparam logic [W-1:0] HALF = {2'b01, 32'h3F00_0000};
  localparam logic [W-1:0] QTR  = {2'b01, 32'h3E80_0000};
  localparam logic [W-1:0] INF  = {2'b10, 32'h0};
  localparam logic [W-1:0] NAN  = {2'b11, 32'h0};
  localparam logic [W-1:0] JUNK = {2'b01, 32'hDEAD_BEEF};

  logic             CLK = 1'b0;
  logic             RESET = 1'b0;
  logic             start = 1'b0;
  logic [W-1:0]     tol = '0;
  logic [W-1:0]     best_error;
  logic [2*W-1:0]   best_roots;
  logic [15:0]      iter_count;
  logic             busy, done;

  nn_root_manager_if #(.W(W), .IDX_W(1)) iface();

  nn_root_manager #(.NUM_UNKNOWNS(2), .MAX_ITER(MAXI), .ITER_W(16), .IDX_W(1)) dut (
    .CLK(CLK), .RESET(RESET), .start(start), .tol(tol), .bus(iface),
    .best_error(best_error), .best_roots(best_roots), .iter_count(iter_count),
    .busy(busy), .done(done)
  );

  always #5 CLK = ~CLK;

  int n_total = 0;
  int n_pass  = 0;

  typedef struct packed {
    logic           rst;
    logic           stall;
    logic [W-1:0]   tol, i0, i1, e0, e1, e2, e3;
    logic [3:0]     nerr;
    logic [W-1:0]   xbest;
    logic [2*W-1:0] xroots;
    logic [3:0]     xiter;
  } vec_t;

  vec_t vt[7];

  logic [W-1:0]   c_tol;
  logic [W-1:0]   c_init[2];
  logic [W-1:0]   c_err[MAXI];
  logic [W-1:0]   c_upd[MAXI][2];
  logic [2*W-1:0] mdl_broots;

  task automatic tick();
    @(posedge CLK); #1;
  endtask

  task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic timeout(string nm);
    n_total++;
    $display("FAIL %s: timeout waiting for handshake", nm);
  endtask

  task automatic do_reset();
    RESET = 1'b1; tick(); tick(); RESET = 1'b0;
    mdl_broots = '0;
  endtask

  function automatic logic [W-1:0] uval(int k, int i);
    return {2'b01, 32'(32'h1000_0000 * (i + 1) + k)};
  endfunction

  // Consume N root beats, checking index/data on every valid cycle (stall stability included)
  task automatic stream_chk(string nm, input logic [2*W-1:0] exp, input bit stall);
    for (int b = 0; b < 2; b++) begin
      int g = 0;
      bit hs = 1'b0;
      while (!hs && g < 64) begin
        iface.fwd_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
        if (iface.fwd_valid) begin
          chk({nm, ":fwd_idx"}, iface.fwd_idx, b);
          chk({nm, ":fwd_data"}, iface.fwd_data, exp[b*W +: W]);
          hs = iface.fwd_ready;
        end
        tick(); g++;
      end
      if (!hs) timeout(nm);
    end
    iface.fwd_ready = 1'b0;
  endtask

  task automatic run_one(string nm, input int nerr, input logic [W-1:0] xbest,
                         input logic [2*W-1:0] xroots, input int xiter, input bit stall);
    logic [2*W-1:0] cur;
    tol = c_tol; start = 1'b1; tick(); start = 1'b0;
    chk({nm, ":init_ready"}, iface.init_ready, 1);
    for (int i = 0; i < 2; i++) begin
      iface.init_valid = 1'b1; iface.init_data = c_init[i]; tick();
    end
    iface.init_valid = 1'b0;
    cur = {c_init[1], c_init[0]};
    for (int it = 0; it < nerr; it++) begin
      stream_chk(nm, cur, stall);
      iface.err_valid = 1'b1; iface.err_data = c_err[it]; tick(); iface.err_valid = 1'b0;
      chk({nm, ":iter_step"}, iter_count, it + 1);
      if (it < nerr - 1) begin
        for (int i = 0; i < 2; i++) begin
          iface.upd_valid = 1'b1; iface.upd_data = c_upd[it][i]; tick();
        end
        iface.upd_valid = 1'b0;
        cur = {c_upd[it][1], c_upd[it][0]};
      end
    end
`ifdef NN_ROOT_BEST_REPLAY_EN
    stream_chk({nm, ":replay"}, xroots, stall);
    chk({nm, ":done"}, done, 1);
`else
    chk({nm, ":finish_not_done"}, done, 0);
    tick();
    chk({nm, ":done"}, done, 1);
`endif
    iface.upd_valid = 1'b1; iface.upd_data = JUNK; tick(); tick(); iface.upd_valid = 1'b0;
    chk({nm, ":done_held"}, done, 1);
    chk({nm, ":busy"}, busy, 0);
    chk({nm, ":iter_count"}, iter_count, xiter);
    chk({nm, ":best_error"}, best_error, xbest);
    chk({nm, ":best_roots"}, best_roots, xroots);
  endtask

  // Reference: walk the error list, keep the first strict minimum, stop at first tol hit or limit
  task automatic model(output int nerr, output logic [W-1:0] xb, output logic [2*W-1:0] xr);
    logic [2*W-1:0] r;
    logic nan;
    xb = INF; xr = mdl_broots; nerr = MAXI;
    for (int k = 0; k < MAXI; k++) begin
      r   = (k == 0) ? {c_init[1], c_init[0]} : {c_upd[k-1][1], c_upd[k-1][0]};
      nan = (c_err[k][W-1 -: 2] == 2'b11);
      if (!nan && c_err[k] < xb) begin xb = c_err[k]; xr = r; end
      if (!nan && c_err[k] <= c_tol) begin nerr = k + 1; break; end
    end
  endtask

  function automatic logic [W-1:0] pick(int r);
    case (r)
      0: return ONE;  1: return TWO;  2: return FOUR; 3: return HALF;
      4: return QTR;  5: return NAN;  6: return INF;  default: return ZERO;
    endcase
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit");
    $fatal(1);
  end

  initial begin
    iface.init_valid = 0; iface.init_data = '0; iface.fwd_ready = 0;
    iface.err_valid = 0; iface.err_data = '0; iface.upd_valid = 0; iface.upd_data = '0;
    #1;

    // Reset defaults
    do_reset();
    chk("rst:best_error", best_error, INF);
    chk("rst:best_roots", best_roots, 0);
    chk("rst:busy", busy, 0);
    chk("rst:done", done, 0);
    chk("rst:fwd_valid", iface.fwd_valid, 0);
    chk("rst:init_ready", iface.init_ready, 0);
    chk("rst:iter_count", iter_count, 0);

    // Start-while-busy, backpressure, stray upd, err on last handshake, mid-run reset
    tol = ZERO; start = 1'b1; tick(); start = 1'b0;
    chk("seq:init_ready", iface.init_ready, 1);
    iface.init_valid = 1'b1; iface.init_data = ONE; tick(); iface.init_valid = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    chk("seq:start_ignored", iface.init_ready, 1);
    iface.init_valid = 1'b1; iface.init_data = TWO; tick(); iface.init_valid = 1'b0;
    chk("seq:load_to_fwd", iface.fwd_valid, 1);
    iface.upd_valid = 1'b1; iface.upd_data = JUNK;
    repeat (3) begin
      chk("seq:stall0_idx", iface.fwd_idx, 0);
      chk("seq:stall0_data", iface.fwd_data, ONE);
      tick();
    end
    iface.fwd_ready = 1'b1; tick(); iface.fwd_ready = 1'b0;
    repeat (3) begin
      chk("seq:stall1_idx", iface.fwd_idx, 1);
      chk("seq:stall1_data", iface.fwd_data, TWO);
      tick();
    end
    iface.upd_valid = 1'b0;
    iface.fwd_ready = 1'b1; iface.err_valid = 1'b1; iface.err_data = ZERO; tick();
    iface.fwd_ready = 1'b0; iface.err_valid = 1'b0;
    chk("seq:early_err_iter", iter_count, 0);
    chk("seq:early_err_busy", busy, 1);
    chk("seq:wait_err_nofwd", iface.fwd_valid, 0);
    iface.err_valid = 1'b1; iface.err_data = FOUR; tick(); iface.err_valid = 1'b0;
    chk("seq:iter1", iter_count, 1);
    chk("seq:best_err1", best_error, FOUR);
    chk("seq:best_roots1", best_roots, {TWO, ONE});
    iface.upd_valid = 1'b1; iface.upd_data = JUNK; tick(); iface.upd_valid = 1'b0;
    RESET = 1'b1; tick(); RESET = 1'b0;
    mdl_broots = '0;
    chk("mrst:busy", busy, 0);
    chk("mrst:done", done, 0);
    chk("mrst:iter", iter_count, 0);
    chk("mrst:best_error", best_error, INF);
    chk("mrst:best_roots", best_roots, 0);
    chk("mrst:fwd_valid", iface.fwd_valid, 0);
    chk("mrst:init_ready", iface.init_ready, 0);

    // Run table
    vt[0] = '{rst:1, stall:1, tol:ZERO, i0:ONE, i1:TWO, e0:FOUR, e1:TWO, e2:FOUR, e3:TWO,
              nerr:4, xbest:TWO, xroots:{uval(0,1), uval(0,0)}, xiter:4};
    vt[1] = '{rst:0, stall:0, tol:HALF, i0:ONE, i1:TWO, e0:FOUR, e1:TWO, e2:QTR, e3:ZERO,
              nerr:3, xbest:QTR, xroots:{uval(1,1), uval(1,0)}, xiter:3};
    vt[2] = '{rst:1, stall:0, tol:HALF, i0:ONE, i1:TWO, e0:NAN, e1:{2'b11,32'h1}, e2:NAN, e3:NAN,
              nerr:4, xbest:INF, xroots:'0, xiter:4};
    vt[3] = '{rst:0, stall:1, tol:TWO, i0:HALF, i1:QTR, e0:TWO, e1:ZERO, e2:ZERO, e3:ZERO,
              nerr:1, xbest:TWO, xroots:{QTR, HALF}, xiter:1};
    vt[4] = '{rst:0, stall:0, tol:HALF, i0:FOUR, i1:ONE, e0:{2'b00,32'h1234_5678}, e1:ZERO, e2:ZERO, e3:ZERO,
              nerr:1, xbest:{2'b00,32'h1234_5678}, xroots:{ONE, FOUR}, xiter:1};
    vt[5] = '{rst:0, stall:0, tol:ZERO, i0:ONE, i1:ONE, e0:INF, e1:NAN, e2:FOUR, e3:NAN,
              nerr:4, xbest:FOUR, xroots:{uval(1,1), uval(1,0)}, xiter:4};
    vt[6] = '{rst:0, stall:0, tol:HALF, i0:TWO, i1:TWO, e0:NAN, e1:NAN, e2:INF, e3:NAN,
              nerr:4, xbest:INF, xroots:{uval(1,1), uval(1,0)}, xiter:4};
    for (int v = 0; v < 7; v++) begin
      if (vt[v].rst) do_reset();
      c_tol = vt[v].tol; c_init[0] = vt[v].i0; c_init[1] = vt[v].i1;
      c_err[0] = vt[v].e0; c_err[1] = vt[v].e1; c_err[2] = vt[v].e2; c_err[3] = vt[v].e3;
      for (int k = 0; k < MAXI; k++)
        for (int i = 0; i < 2; i++) c_upd[k][i] = uval(k, i);
      run_one($sformatf("vec%0d", v), int'(vt[v].nerr), vt[v].xbest, vt[v].xroots,
              int'(vt[v].xiter), vt[v].stall);
      mdl_broots = vt[v].xroots;
    end

    // Random runs against the model
    for (int r = 0; r < 24; r++) begin
      int nerr;
      logic [W-1:0] xb;
      logic [2*W-1:0] xr;
      if ($urandom_range(0, 5) == 0) do_reset();
      c_tol = pick(($urandom_range(0, 3) == 0) ? 7 : int'($urandom_range(0, 4)));
      for (int i = 0; i < 2; i++) c_init[i] = {2'b01, 32'($urandom)};
      for (int k = 0; k < MAXI; k++) begin
        c_err[k] = pick(int'($urandom_range(0, 7)));
        for (int i = 0; i < 2; i++) c_upd[k][i] = {2'($urandom), 32'($urandom)};
      end
      model(nerr, xb, xr);
      run_one($sformatf("rnd%0d", r), nerr, xb, xr, nerr, 1'($urandom_range(0, 1)));
      mdl_broots = xr;
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
